alu_exec_unit: RTL and testbench
================================

# alu_exec_unit

Parametrised execute-stage unit for the pipelined MIPS core, merging ALU-control decode, the ALU datapath and an iterative multiply/divide engine with HI/LO registers. It extends the 2-bit ALUOp/funct decode with shifts, xor/nor, unsigned compare and mult/div/mfhi/mflo. Sits between the ID/EX and EX/MEM pipeline registers and drives a stall request to the hazard unit while mult/div is in flight.

## Interface
- WIDTH, 32: datapath width (≥8, even)
- SHAMT_W, 5: shift-amount width; must be ≥ clog2(WIDTH)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- valid_in  in  1  instruction present in EX
- ready_out  out  1  unit accepts; equals !busy
- flush  in  1  cancels this cycle's accept; in-flight mult/div continues
- alu_op  in  2  00 add, 01/11 sub, 10 funct decode
- funct  in  6  R-type funct field
- shamt  in  SHAMT_W  shift amount
- a, b  in  WIDTH  operands (rs, rt/imm)
- result  out  WIDTH  registered result
- zero  out  1  registered (result == 0)
- result_valid  out  1  one-cycle pulse per completed single-cycle op
- alu_ctrl  out  4  registered decoded control code (debug/trace)
- illegal  out  1  one-cycle pulse: alu_op=10 with unsupported funct
- busy  out  1  mult/div in progress; stall request
- hi, lo  out  WIDTH  HI/LO architectural registers

## Operation
- Accept = valid_in & ready_out & !flush.
- ctrl codes: and 0000, or 0001, add/addu 0010, xor 0011, sub/subu 0110, slt 0111, sltu 1000, sll 1001, srl 1010, sra 1011, nor 1100, mfhi 1101, mflo 1110, muldiv 1111.
- funct: 100000/100001 add, 100010/100011 sub, 100100 and, 100101 or, 100110 xor, 100111 nor, 101010 slt (signed), 101011 sltu, 000000 sll, 000010 srl, 000011 sra (shift b by shamt), 010000 mfhi, 010010 mflo, 011000 mult, 011001 multu, 011010 div, 011011 divu.
- Add/sub wrap modulo 2^WIDTH; no overflow trap. slt/sltu yield 1 or 0 zero-extended.
- Illegal funct: result 0, result_valid 1, illegal pulse, HI/LO unchanged.
- mult/multu: {hi,lo} = 2*WIDTH-bit product. div/divu: lo = quotient, hi = remainder; signed quotient truncates toward zero, remainder takes dividend sign.
- Divide by zero: lo = all ones, hi = a; takes full latency; no flag.
- mfhi/mflo read HI/LO only when not busy (guaranteed by ready_out).
- mult/div accept produces no result_valid.
- Muldiv FSM: IDLE → (accept muldiv) RUN → after WIDTH iterations DONE → IDLE. Signed ops: operands absolute-valued on entry, signs fixed in DONE.

## Timing
- Reset: result 0, zero 1, result_valid 0, alu_ctrl 0000, illegal 0, busy 0, ready_out 1, hi 0, lo 0, FSM IDLE.
- Single-cycle ops: accept at edge N → result/zero/alu_ctrl/result_valid visible after edge N+1 (latency 1); back-to-back accepts each cycle.
- Mult/div accepted at edge N: busy high after edge N through edge N+WIDTH+1; hi/lo updated at edge N+WIDTH+1 (DONE), busy and ready_out restored after the same edge; next instruction accepted at edge N+WIDTH+2 earliest.
- Valid_in while busy: not accepted; requester holds inputs.
- Flush with valid_in: no state change, no pulses.
- Reset asserted mid-RUN: immediate abort, all outputs to reset values; HI/LO 0.
- result/zero hold last value when result_valid is 0.

## Structure
- Package alu_pkg: ALUOp localparams, funct localparams, 4-bit ctrl codes, muldiv FSM state enum.
- Sub-module muldiv_iter (shift-add multiplier / restoring divider, start/done handshake, signed fix-up); top holds decode, ALU, HI/LO and output registers.

## Test plan
- Reset mid-RUN: after 5 cycles of mult, drop rst_n → busy 0, hi=lo=0, ready_out 1 immediately.
- alu_op=10, funct=101010, a=0xFFFFFFFF, b=1 → result 1, alu_ctrl 0111; funct=101011 same operands → result 0, zero 1.
- alu_op=01, a=b=0x1234 → result 0, zero 1, alu_ctrl 0110, one cycle after accept.
- mult a=-3, b=7 → busy 33 cycles of stall window, hi=0xFFFFFFFF, lo=0xFFFFFFEB; then mflo → result 0xFFFFFFEB.
- div a=-7, b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu a=10, b=0 → lo=0xFFFFFFFF, hi=10.
- funct=111111 → illegal pulse, result 0; flush with valid_in on an add → no result_valid, result unchanged.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALUOp, funct and control encodings plus the mult/div FSM states
package alu_pkg;
  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_ADDU  = 6'b100001;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SUBU  = 6'b100011;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLTU  = 6'b101011;
  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_SRA   = 6'b000011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [3:0] C_AND    = 4'b0000;
  localparam logic [3:0] C_OR     = 4'b0001;
  localparam logic [3:0] C_ADD    = 4'b0010;
  localparam logic [3:0] C_XOR    = 4'b0011;
  localparam logic [3:0] C_SUB    = 4'b0110;
  localparam logic [3:0] C_SLT    = 4'b0111;
  localparam logic [3:0] C_SLTU   = 4'b1000;
  localparam logic [3:0] C_SLL    = 4'b1001;
  localparam logic [3:0] C_SRL    = 4'b1010;
  localparam logic [3:0] C_SRA    = 4'b1011;
  localparam logic [3:0] C_NOR    = 4'b1100;
  localparam logic [3:0] C_MFHI   = 4'b1101;
  localparam logic [3:0] C_MFLO   = 4'b1110;
  localparam logic [3:0] C_MULDIV = 4'b1111;
  typedef enum logic [1:0] {MD_IDLE, MD_RUN, MD_DONE} md_state_t;
endpackage

// File: rtl/alu_exec_unit_muldiv.sv
// muldiv_iter: shift-add multiplier / restoring divider on magnitudes, sign fix-up in DONE
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);
  localparam int CW = $clog2(WIDTH);
  md_state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] r, q, m, ma, mb, diff;
  logic [WIDTH:0] sum, trial;
  logic [2*WIDTH-1:0] prod;
  logic is_div, neg_p, neg_q, neg_r, sa, sb, ge;
  assign sa = !op[0] & a[WIDTH-1];
  assign sb = !op[0] & b[WIDTH-1];
  assign ma = sa ? -a : a;
  assign mb = sb ? -b : b;
  assign sum = {1'b0, r} + (q[0] ? {1'b0, m} : '0);
  assign trial = {r, q[WIDTH-1]};
  assign ge = trial >= {1'b0, m};
  assign diff = trial[WIDTH-1:0] - m;
  assign prod = neg_p ? -{r, q} : {r, q};
  assign busy = state != MD_IDLE;
  assign done = state == MD_DONE;
  assign res_hi = is_div ? (neg_r ? -r : r) : prod[2*WIDTH-1:WIDTH];
  assign res_lo = is_div ? (neg_q ? -q : q) : prod[WIDTH-1:0];
  always_comb begin
    state_nx = MD_IDLE;
    if (state == MD_IDLE) state_nx = start ? MD_RUN : MD_IDLE;
    else if (state == MD_RUN) state_nx = cnt == CW'(WIDTH-1) ? MD_DONE : MD_RUN;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= MD_IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      r <= '0;
      q <= '0;
      m <= '0;
      is_div <= 1'b0;
      neg_p <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (state == MD_IDLE && start) begin
      cnt <= '0;
      r <= '0;
      q <= ma;
      m <= mb;
      is_div <= op[1];
      neg_p <= sa ^ sb;
      // a zero divisor must leave the quotient all ones regardless of sign
      neg_q <= (sa ^ sb) & (b != '0);
      neg_r <= sa;
    end else if (state == MD_RUN) begin
      cnt <= cnt + 1'b1;
      if (is_div) begin
        r <= ge ? diff : trial[WIDTH-1:0];
        q <= {q[WIDTH-2:0], ge};
      end else begin
        r <= sum[WIDTH:1];
        q <= {sum[0], q[WIDTH-1:1]};
      end
    end
  end
endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: EX-stage decode, single-cycle ALU, HI/LO and iterative mult/div with stall
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               valid_in,
  output logic               ready_out,
  input  logic               flush,
  input  logic [1:0]         alu_op,
  input  logic [5:0]         funct,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [WIDTH-1:0]   result,
  output logic               zero,
  output logic               result_valid,
  output logic [3:0]         alu_ctrl,
  output logic               illegal,
  output logic               busy,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);
  logic accept, is_md, ill_d, md_done;
  logic [3:0] ctrl;
  logic [WIDTH-1:0] alu_res, md_hi, md_lo;
  assign ready_out = !busy;
  assign accept = valid_in & ready_out & !flush;
  assign is_md = ctrl == C_MULDIV;
  always_comb begin
    ctrl = C_AND;
    ill_d = 1'b0;
    if (alu_op == ALUOP_ADD) ctrl = C_ADD;
    else if (alu_op[0]) ctrl = C_SUB;
    else
      case (funct)
        F_ADD, F_ADDU: ctrl = C_ADD;
        F_SUB, F_SUBU: ctrl = C_SUB;
        F_AND: ctrl = C_AND;
        F_OR: ctrl = C_OR;
        F_XOR: ctrl = C_XOR;
        F_NOR: ctrl = C_NOR;
        F_SLT: ctrl = C_SLT;
        F_SLTU: ctrl = C_SLTU;
        F_SLL: ctrl = C_SLL;
        F_SRL: ctrl = C_SRL;
        F_SRA: ctrl = C_SRA;
        F_MFHI: ctrl = C_MFHI;
        F_MFLO: ctrl = C_MFLO;
        F_MULT, F_MULTU, F_DIV, F_DIVU: ctrl = C_MULDIV;
        default: ill_d = 1'b1;
      endcase
  end
  always_comb begin
    alu_res = '0;
    case (ctrl)
      C_AND: alu_res = a & b;
      C_OR: alu_res = a | b;
      C_ADD: alu_res = a + b;
      C_XOR: alu_res = a ^ b;
      C_SUB: alu_res = a - b;
      C_SLT: alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      C_SLTU: alu_res = {{(WIDTH-1){1'b0}}, a < b};
      C_SLL: alu_res = b << shamt;
      C_SRL: alu_res = b >> shamt;
      C_SRA: alu_res = $signed(b) >>> shamt;
      C_NOR: alu_res = ~(a | b);
      C_MFHI: alu_res = hi;
      C_MFLO: alu_res = lo;
      default: alu_res = '0;
    endcase
  end
  muldiv_iter #(.WIDTH(WIDTH)) u_md (
    .clk(clk),
    .rst_n(rst_n),
    .start(accept & is_md),
    .op(funct[1:0]),
    .a(a),
    .b(b),
    .busy(busy),
    .done(md_done),
    .res_hi(md_hi),
    .res_lo(md_lo)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
      zero <= 1'b1;
      result_valid <= 1'b0;
      alu_ctrl <= C_AND;
      illegal <= 1'b0;
      hi <= '0;
      lo <= '0;
    end else begin
      result_valid <= accept & !is_md;
      illegal <= accept & ill_d;
      if (accept) alu_ctrl <= ctrl;
      if (accept & !is_md) begin
        result <= ill_d ? '0 : alu_res;
        zero <= ill_d | (alu_res == '0);
      end
      if (md_done) begin
        hi <= md_hi;
        lo <= md_lo;
      end
    end
  end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed literal checks plus randomized run against a behavioural model
module tb_alu_exec_unit;
  logic clk = 1'b0;
  logic rst_n, valid_in, flush, ready_out, zero, result_valid, illegal, busy;
  logic [1:0] alu_op;
  logic [5:0] funct;
  logic [4:0] shamt;
  logic [31:0] a, b, result, hi, lo;
  logic [3:0] alu_ctrl;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_exec_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .ready_out(ready_out), .flush(flush),
    .alu_op(alu_op), .funct(funct), .shamt(shamt), .a(a), .b(b), .result(result),
    .zero(zero), .result_valid(result_valid), .alu_ctrl(alu_ctrl), .illegal(illegal),
    .busy(busy), .hi(hi), .lo(lo)
  );

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  ctrl;
    logic        ill;
    logic        md;
    logic [31:0] ph;
    logic [31:0] pl;
  } exp_t;

  function automatic exp_t model(input logic [1:0] op, input logic [5:0] f, input logic [4:0] sh,
                                 input logic [31:0] x, input logic [31:0] y,
                                 input logic [31:0] h, input logic [31:0] l);
    exp_t e;
    logic [63:0] p;
    longint qq, rr;
    e = '0;
    p = '0;
    if (op == 2'b00) begin e.res = x + y; e.ctrl = 4'd2; end
    else if (op[0]) begin e.res = x - y; e.ctrl = 4'd6; end
    else
      case (f)
        6'h20, 6'h21: begin e.res = x + y; e.ctrl = 4'd2; end
        6'h22, 6'h23: begin e.res = x - y; e.ctrl = 4'd6; end
        6'h24: begin e.res = x & y; e.ctrl = 4'd0; end
        6'h25: begin e.res = x | y; e.ctrl = 4'd1; end
        6'h26: begin e.res = x ^ y; e.ctrl = 4'd3; end
        6'h27: begin e.res = ~(x | y); e.ctrl = 4'd12; end
        6'h2a: begin e.res = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0; e.ctrl = 4'd7; end
        6'h2b: begin e.res = (x < y) ? 32'd1 : 32'd0; e.ctrl = 4'd8; end
        6'h00: begin e.res = y << sh; e.ctrl = 4'd9; end
        6'h02: begin e.res = y >> sh; e.ctrl = 4'd10; end
        6'h03: begin e.res = $signed(y) >>> sh; e.ctrl = 4'd11; end
        6'h10: begin e.res = h; e.ctrl = 4'd13; end
        6'h12: begin e.res = l; e.ctrl = 4'd14; end
        6'h18, 6'h19, 6'h1a, 6'h1b: begin
          e.md = 1'b1;
          e.ctrl = 4'd15;
          if (f == 6'h18) p = {{32{x[31]}}, x} * {{32{y[31]}}, y};
          else if (f == 6'h19) p = {32'd0, x} * {32'd0, y};
          else if (y == 32'd0) p = {x, 32'hFFFF_FFFF};
          else if (f == 6'h1a) begin
            qq = longint'($signed(x)) / longint'($signed(y));
            rr = longint'($signed(x)) % longint'($signed(y));
            p = {32'(rr), 32'(qq)};
          end else p = {x % y, x / y};
          e.ph = p[63:32];
          e.pl = p[31:0];
        end
        default: e.ill = 1'b1;
      endcase
    return e;
  endfunction

  logic [31:0] m_result, m_hi, m_lo, m_ph, m_pl;
  logic m_zero, m_rv, m_ill;
  logic [3:0] m_ctrl;
  int m_cnt;
  exp_t e;
  logic acc;

  always_comb e = model(alu_op, funct, shamt, a, b, m_hi, m_lo);
  always_comb acc = valid_in && m_cnt == 0 && !flush;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_result <= 0; m_zero <= 1; m_rv <= 0; m_ill <= 0; m_ctrl <= 0;
      m_hi <= 0; m_lo <= 0; m_ph <= 0; m_pl <= 0; m_cnt <= 0;
    end else begin
      m_rv <= acc && !e.md;
      m_ill <= acc && e.ill;
      if (acc) m_ctrl <= e.ctrl;
      if (acc && !e.md) begin
        m_result <= e.res;
        m_zero <= e.res == 32'd0;
      end
      if (acc && e.md) begin
        m_cnt <= 33;
        m_ph <= e.ph;
        m_pl <= e.pl;
      end else if (m_cnt != 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_hi <= m_ph;
          m_lo <= m_pl;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_result", result, m_result);
      chk("m_zero", 32'(zero), 32'(m_zero));
      chk("m_valid", 32'(result_valid), 32'(m_rv));
      chk("m_illegal", 32'(illegal), 32'(m_ill));
      chk("m_busy", 32'(busy), 32'(m_cnt != 0));
      chk("m_ready", 32'(ready_out), 32'(m_cnt == 0));
      chk("m_hi", hi, m_hi);
      chk("m_lo", lo, m_lo);
      if (m_rv && !m_ill) chk("m_ctrl", 32'(alu_ctrl), 32'(m_ctrl));
    end
  end

  task automatic issue(input logic [1:0] op, input logic [5:0] f, input logic [31:0] x,
                       input logic [31:0] y, input logic fl);
    valid_in = 1'b1; flush = fl; alu_op = op; funct = f; shamt = 5'd0; a = x; b = y;
    @(posedge clk); #1;
    valid_in = 1'b0; flush = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  logic [5:0] ft [18] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a,
                          6'h2b, 6'h00, 6'h02, 6'h03, 6'h10, 6'h12, 6'h18, 6'h19, 6'h1a};
  logic [31:0] sp [6] = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 32'h2};

  function automatic logic [31:0] pick();
    return ($urandom_range(0, 3) == 0) ? sp[$urandom_range(0, 5)] : $urandom;
  endfunction

  initial begin
    int n, r;
    rst_n = 1'b0; valid_in = 1'b0; flush = 1'b0; alu_op = 2'b00; funct = 6'h0;
    shamt = 5'd0; a = 0; b = 0;
    #12;
    chk("rst_result", result, 32'h0);
    chk("rst_zero", 32'(zero), 32'd1);
    chk("rst_valid", 32'(result_valid), 32'd0);
    chk("rst_ctrl", 32'(alu_ctrl), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(ready_out), 32'd1);
    chk("rst_hilo", hi | lo, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue(2'b10, 6'h2a, 32'hFFFF_FFFF, 32'd1, 1'b0);
    chk("slt_res", result, 32'd1);
    chk("slt_ctrl", 32'(alu_ctrl), 32'd7);
    chk("slt_valid", 32'(result_valid), 32'd1);
    issue(2'b10, 6'h2b, 32'hFFFF_FFFF, 32'd1, 1'b0);
    chk("sltu_res", result, 32'd0);
    chk("sltu_zero", 32'(zero), 32'd1);
    issue(2'b00, 6'h00, 32'd5, 32'd6, 1'b0);
    chk("add_res", result, 32'd11);
    chk("add_zero", 32'(zero), 32'd0);
    issue(2'b01, 6'h00, 32'h1234, 32'h1234, 1'b0);
    chk("sub_res", result, 32'd0);
    chk("sub_zero", 32'(zero), 32'd1);
    chk("sub_ctrl", 32'(alu_ctrl), 32'd6);
    issue(2'b10, 6'h18, 32'hFFFF_FFFD, 32'd7, 1'b0);
    chk("mult_novalid", 32'(result_valid), 32'd0);
    chk("mult_busy", 32'(busy), 32'd1);
    wait_idle(n);
    chk("mult_stall", n, 32'd33);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFEB);
    issue(2'b10, 6'h12, 32'd0, 32'd0, 1'b0);
    chk("mflo_res", result, 32'hFFFF_FFEB);
    issue(2'b10, 6'h1a, 32'hFFFF_FFF9, 32'd2, 1'b0);
    wait_idle(n);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);
    issue(2'b10, 6'h1b, 32'd10, 32'd0, 1'b0);
    wait_idle(n);
    chk("divu0_lo", lo, 32'hFFFF_FFFF);
    chk("divu0_hi", hi, 32'd10);
    issue(2'b10, 6'h3f, 32'd5, 32'd3, 1'b0);
    chk("ill_pulse", 32'(illegal), 32'd1);
    chk("ill_res", result, 32'd0);
    chk("ill_valid", 32'(result_valid), 32'd1);
    @(posedge clk); #1;
    chk("ill_drop", 32'(illegal), 32'd0);
    issue(2'b00, 6'h00, 32'd5, 32'd6, 1'b0);
    issue(2'b00, 6'h00, 32'd1, 32'd1, 1'b1);
    chk("flush_valid", 32'(result_valid), 32'd0);
    chk("flush_res", result, 32'd11);
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 7);
      valid_in = $urandom_range(0, 3) != 0;
      flush = $urandom_range(0, 7) == 0;
      alu_op = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : (r == 2) ? 2'b11 : 2'b10;
      funct = ($urandom_range(0, 15) == 0) ? 6'($urandom) : ft[$urandom_range(0, 17)];
      if (funct == 6'h1a && $urandom_range(0, 1) == 0) funct = 6'h1b;
      shamt = 5'($urandom);
      a = pick();
      b = pick();
      @(posedge clk); #1;
    end
    valid_in = 1'b0; flush = 1'b0;
    wait_idle(n);
    chk("rand_drain", 32'(busy), 32'd0);
    issue(2'b10, 6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_ready", 32'(ready_out), 32'd1);
    chk("arst_hi", hi, 32'd0);
    chk("arst_lo", lo, 32'd0);
    chk("arst_zero", 32'(zero), 32'd1);
    #2 rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("arst_stay", 32'(busy), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
